thor2024_nop_squash: RTL and testbench

- Multi-lane, registered successor to the single-instruction NOP detector. Sits between the fetch-align stage and the decoders.
- Per fetch group it:
  - classifies each lane;
  - discards squashable NOP-class instructions (runtime-selectable classes);
  - strips OP_PFX lanes and attaches them to the following surviving instruction, carrying pending prefixes across group boundaries;
  - compacts survivors toward lane 0;
  - presents the result one cycle later under a valid/ready handshake.

---
 rtl/thor2024_nop_squash_pkg.sv | 51 +++++
 rtl/thor2024_nop_squash_lane_compact.sv | 50 +++++
 rtl/thor2024_nop_squash.sv | 163 ++++++++++++++++
 tb/tb_thor2024_nop_squash.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2024_nop_squash_pkg.sv
// Shared types for the NOP-squash stage: instruction word, opcodes and NOP classes.
// Pure declarations; no logic and no latency.
// No flow control here; the handshake lives in the top module.
package thor2024_nop_squash_pkg;

  localparam int PFX_MAX_DEF = 2;

  localparam logic [6:0] OP_NOP   = 7'h01;
  localparam logic [6:0] OP_ENTER = 7'h02;
  localparam logic [6:0] OP_LEAVE = 7'h03;
  localparam logic [6:0] OP_PUSH  = 7'h04;
  localparam logic [6:0] OP_POP   = 7'h05;
  localparam logic [6:0] OP_ATOM  = 7'h06;
  localparam logic [6:0] OP_PFX   = 7'h07;
  localparam logic [6:0] OP_ADD   = 7'h10;
  localparam logic [6:0] OP_SUB   = 7'h11;
  localparam logic [6:0] OP_LDO   = 7'h20;

  typedef struct packed {
    logic [24:0] payload;
    logic [6:0]  opcode;
  } instruction_t;

  // Prefix slots attached to one instruction, oldest in slot 0.
  typedef instruction_t [PFX_MAX_DEF-1:0] pfx_vec_t;

  // Values are the bit positions in sq_mask; NC_NONE never squashes.
  typedef enum logic [2:0] {
    NC_NOP   = 3'd0,
    NC_ENTER = 3'd1,
    NC_LEAVE = 3'd2,
    NC_PUSH  = 3'd3,
    NC_POP   = 3'd4,
    NC_ATOM  = 3'd5,
    NC_NONE  = 3'd7
  } nop_class_t;

  // Only the opcode decides the class, so only the opcode is passed in.
  function automatic nop_class_t fnNopClass(input logic [6:0] op);
    case (op)
      OP_NOP:   return NC_NOP;
      OP_ENTER: return NC_ENTER;
      OP_LEAVE: return NC_LEAVE;
      OP_PUSH:  return NC_PUSH;
      OP_POP:   return NC_POP;
      OP_ATOM:  return NC_ATOM;
      default:  return NC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/thor2024_nop_squash_lane_compact.sv
// Packs kept lanes, with their prefixes, toward lane 0 in program order.
// Combinational, zero latency.
// No flow control; unused output slots are driven to zero.
module thor2024_nop_squash_lane_compact
  import thor2024_nop_squash_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int PFX_MAX = 2,
  parameter int CW      = 2,
  parameter int NW      = 3
) (
  input  logic         [LANES-1:0]                keep_i,
  input  instruction_t [LANES-1:0]                instr_i,
  input  instruction_t [LANES-1:0][PFX_MAX-1:0]   pfx_i,
  input  logic         [LANES-1:0][CW-1:0]        pfx_cnt_i,
  output logic         [LANES-1:0]                lane_v_o,
  output instruction_t [LANES-1:0]                instr_o,
  output instruction_t [LANES-1:0][PFX_MAX-1:0]   pfx_o,
  output logic         [LANES-1:0][CW-1:0]        pfx_cnt_o,
  output logic         [NW-1:0]                   n_o
);

  int pos;

  // Walk input lanes in order; each kept lane lands in the next free output slot.
  always_comb begin
    lane_v_o  = '0;
    instr_o   = '0;
    pfx_o     = '0;
    pfx_cnt_o = '0;
    pos       = 0;
    for (int i = 0; i < LANES; i++) begin
      if (keep_i[i]) begin
        for (int j = 0; j < LANES; j++) begin
          if (j == pos) begin
            instr_o[j]   = instr_i[i];
            pfx_o[j]     = pfx_i[i];
            pfx_cnt_o[j] = pfx_cnt_i[i];
          end
        end
        pos = pos + 1;
      end
    end
    for (int j = 0; j < LANES; j++) begin
      lane_v_o[j] = (j < pos);
    end
    n_o = NW'(pos);
  end

endmodule

// File: rtl/thor2024_nop_squash.sv
// Squashes NOP-class lanes, attaches prefixes to the next survivor and compacts the group.
// Latency: exactly one cycle from accept to registered output.
// Backpressure: in_ready = !out_valid | out_ready; output held while out_valid & !out_ready.
module thor2024_nop_squash
  import thor2024_nop_squash_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int PFX_MAX = 2,
  parameter int CNT_W   = 32,
  localparam int CW     = $clog2(PFX_MAX + 1),
  localparam int NW     = $clog2(LANES + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic         [5:0]                      sq_mask,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic         [LANES-1:0]                in_lane_v,
  input  instruction_t [LANES-1:0]                in_instr,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic         [LANES-1:0]                out_lane_v,
  output instruction_t [LANES-1:0]                out_instr,
  output instruction_t [LANES-1:0][PFX_MAX-1:0]   out_pfx,
  output logic         [LANES-1:0][CW-1:0]        out_pfx_cnt,
  output logic                                    pfx_ovf,
  output logic         [CNT_W-1:0]                nop_count
);

  logic                                  accept;
  logic         [LANES-1:0]              keep;
  instruction_t [LANES-1:0][PFX_MAX-1:0] lane_pfx;
  logic         [LANES-1:0][CW-1:0]      lane_cnt;
  instruction_t [PFX_MAX-1:0]            pend_q, pend_d;
  logic         [CW-1:0]                 pend_cnt_q, pend_cnt_d;
  logic                                  ovf_d;
  int                                    cnt;
  int                                    sq_n;
  logic                                  run;
  nop_class_t                            cls;

  logic         [LANES-1:0]              c_lane_v;
  instruction_t [LANES-1:0]              c_instr;
  instruction_t [LANES-1:0][PFX_MAX-1:0] c_pfx;
  logic         [LANES-1:0][CW-1:0]      c_pfx_cnt;
  logic         [NW-1:0]                 c_n;

  logic                                  out_valid_q;
  logic         [LANES-1:0]              out_lane_v_q;
  instruction_t [LANES-1:0]              out_instr_q;
  instruction_t [LANES-1:0][PFX_MAX-1:0] out_pfx_q;
  logic         [LANES-1:0][CW-1:0]      out_pfx_cnt_q;
  logic                                  pfx_ovf_q;
  logic         [CNT_W-1:0]              nop_count_q, nop_count_d;
  logic         [CNT_W:0]                nop_sum;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Scan lanes in program order: classify, run the prefix machine, mark survivors.
  always_comb begin
    keep     = '0;
    lane_pfx = '0;
    lane_cnt = '0;
    pend_d   = pend_q;
    cnt      = int'(pend_cnt_q);
    ovf_d    = 1'b0;
    sq_n     = 0;
    run      = 1'b1;
    cls      = NC_NONE;
    for (int i = 0; i < LANES; i++) begin
      // A hole in in_lane_v ends the group; later lanes are ignored.
      run = run & in_lane_v[i];
      if (run) begin
        if (in_instr[i].opcode == OP_PFX) begin
          if (cnt == PFX_MAX) begin
            ovf_d = 1'b1;
          end else begin
            for (int s = 0; s < PFX_MAX; s++) begin
              if (s == cnt) pend_d[s] = in_instr[i];
            end
            cnt = cnt + 1;
          end
        end else begin
          cls = fnNopClass(in_instr[i].opcode);
          if (cls != NC_NONE && sq_mask[cls]) begin
            sq_n = sq_n + 1;
          end else begin
            keep[i]     = 1'b1;
            lane_pfx[i] = pend_d;
            lane_cnt[i] = CW'(cnt);
          end
          // Kept or squashed, this lane consumes whatever prefixes were pending.
          pend_d = '0;
          cnt    = 0;
        end
      end
    end
    pend_cnt_d = CW'(cnt);
  end

  assign nop_sum     = {1'b0, nop_count_q} + (CNT_W + 1)'(sq_n);
  assign nop_count_d = nop_sum[CNT_W] ? '1 : nop_sum[CNT_W-1:0];

  thor2024_nop_squash_lane_compact #(
    .LANES   (LANES),
    .PFX_MAX (PFX_MAX),
    .CW      (CW),
    .NW      (NW)
  ) u_compact (
    .keep_i    (keep),
    .instr_i   (in_instr),
    .pfx_i     (lane_pfx),
    .pfx_cnt_i (lane_cnt),
    .lane_v_o  (c_lane_v),
    .instr_o   (c_instr),
    .pfx_o     (c_pfx),
    .pfx_cnt_o (c_pfx_cnt),
    .n_o       (c_n)
  );

  // Output register, pending prefixes, overflow flag and counter; flush beats accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_lane_v_q  <= '0;
      out_instr_q   <= '0;
      out_pfx_q     <= '0;
      out_pfx_cnt_q <= '0;
      pend_q        <= '0;
      pend_cnt_q    <= '0;
      pfx_ovf_q     <= 1'b0;
      nop_count_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      pend_q      <= '0;
      pend_cnt_q  <= '0;
    end else if (accept) begin
      // An all-squashed group loads an empty result and produces no beat.
      out_valid_q   <= (c_n != '0);
      out_lane_v_q  <= c_lane_v;
      out_instr_q   <= c_instr;
      out_pfx_q     <= c_pfx;
      out_pfx_cnt_q <= c_pfx_cnt;
      pend_q        <= pend_d;
      pend_cnt_q    <= pend_cnt_d;
      pfx_ovf_q     <= pfx_ovf_q | ovf_d;
      nop_count_q   <= nop_count_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_lane_v  = out_lane_v_q;
  assign out_instr   = out_instr_q;
  assign out_pfx     = out_pfx_q;
  assign out_pfx_cnt = out_pfx_cnt_q;
  assign pfx_ovf     = pfx_ovf_q;
  assign nop_count   = nop_count_q;

endmodule

// File: tb/tb_thor2024_nop_squash.sv
// Bench for thor2024_nop_squash: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the squash/prefix rules.
module tb_thor2024_nop_squash;
  import thor2024_nop_squash_pkg::*;

  localparam int LANES   = 4;
  localparam int PFX_MAX = 2;
  localparam int CNT_W   = 5;
  localparam int CW      = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int PW      = 448;

  typedef instruction_t [LANES-1:0] grp_t;

  logic                                  clk, rst, flush, in_valid, in_ready;
  logic                                  out_valid, out_ready, pfx_ovf;
  logic         [5:0]                    sq_mask;
  logic         [LANES-1:0]              in_lane_v, out_lane_v;
  instruction_t [LANES-1:0]              in_instr, out_instr;
  instruction_t [LANES-1:0][PFX_MAX-1:0] out_pfx;
  logic         [LANES-1:0][CW-1:0]      out_pfx_cnt;
  logic         [CNT_W-1:0]              nop_count;

  thor2024_nop_squash #(.LANES(LANES), .PFX_MAX(PFX_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sq_mask(sq_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_v(in_lane_v), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_v(out_lane_v),
    .out_instr(out_instr), .out_pfx(out_pfx), .out_pfx_cnt(out_pfx_cnt),
    .pfx_ovf(pfx_ovf), .nop_count(nop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;
  bit rdy_seen, rdy_exp;

  // Reference model state
  bit           m_valid, m_ovf;
  int           m_n, m_cnt;
  instruction_t m_instr [LANES];
  instruction_t m_pfx   [LANES][PFX_MAX];
  int           m_pcnt  [LANES];
  instruction_t pend    [$];

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_NOP: return 0;   OP_ENTER: return 1; OP_LEAVE: return 2;
      OP_PUSH: return 3;  OP_POP: return 4;   OP_ATOM: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic instruction_t mk(input logic [6:0] op);
    instruction_t t;
    t.opcode  = op;
    t.payload = 25'($urandom);
    return t;
  endfunction

  function automatic grp_t g4(input instruction_t a, b, c, d);
    grp_t g;
    g[0] = a; g[1] = b; g[2] = c; g[3] = d;
    return g;
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 11))
      0: return OP_NOP;   1: return OP_ENTER; 2: return OP_LEAVE;
      3: return OP_PUSH;  4: return OP_POP;   5: return OP_ATOM;
      6: return OP_ADD;   7: return OP_SUB;   8: return OP_LDO;
      default: return OP_PFX;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ovf = 0; m_n = 0; m_cnt = 0;
    pend.delete();
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step(input bit v, input logic [LANES-1:0] lv, input grp_t ins,
                            input bit fl, input bit ordy);
    bit acc;
    acc = v && (!m_valid || ordy);
    if (fl) begin
      m_valid = 0;
      pend.delete();
    end else if (acc) begin
      m_n = 0;
      for (int i = 0; i < LANES; i++) begin
        if (!lv[i]) break;
        if (ins[i].opcode == OP_PFX) begin
          if (pend.size() == PFX_MAX) m_ovf = 1;
          else pend.push_back(ins[i]);
        end else begin
          int c;
          c = cls_of(ins[i].opcode);
          if (c >= 0 && sq_mask[c]) begin
            if (m_cnt < CMAX) m_cnt++;
          end else begin
            m_instr[m_n] = ins[i];
            m_pcnt[m_n]  = pend.size();
            foreach (pend[s]) m_pfx[m_n][s] = pend[s];
            m_n++;
          end
          pend.delete();
        end
      end
      m_valid = (m_n != 0);
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  // Packs the observable outputs (dut=1) or the model's expectation (dut=0);
  // lane data is only packed for lanes and prefix slots the model says are live.
  function automatic logic [PW-1:0] pack(input bit dut);
    logic [PW-1:0] r;
    logic [31:0]   w;
    r = '0;
    r = (r << 1) | PW'(dut ? out_valid : m_valid);
    r = (r << 1) | PW'(dut ? pfx_ovf : m_ovf);
    r = (r << CNT_W) | PW'(dut ? nop_count : CNT_W'(m_cnt));
    if (m_valid) begin
      r = (r << LANES) | PW'(dut ? out_lane_v : LANES'((1 << m_n) - 1));
      for (int j = 0; j < m_n; j++) begin
        w = dut ? out_instr[j] : m_instr[j];
        r = (r << 32) | PW'(w);
        r = (r << CW) | PW'(dut ? out_pfx_cnt[j] : CW'(m_pcnt[j]));
        for (int s = 0; s < m_pcnt[j]; s++) begin
          w = dut ? out_pfx[j][s] : m_pfx[j][s];
          r = (r << 32) | PW'(w);
        end
      end
    end
    return r;
  endfunction

  // Drive one cycle of inputs, sample in_ready before the edge, advance the model.
  task automatic apply(input bit v, input logic [LANES-1:0] lv, input grp_t ins,
                       input bit fl, input bit ordy);
    in_valid = v; in_lane_v = lv; in_instr = ins; flush = fl; out_ready = ordy;
    #2;
    rdy_seen = in_ready;
    rdy_exp  = !m_valid || ordy;
    @(posedge clk);
    model_step(v, lv, ins, fl, ordy);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_lane_v = '0; in_instr = '0;
    sq_mask = 6'h3F;
    #1 rst = 1'b0;
    #2;
    model_reset();
    vecs++;
    if ({out_valid, out_lane_v, out_instr, out_pfx, out_pfx_cnt, pfx_ovf, nop_count} !== '0
        || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b lane_v=%b ovf=%b cnt=%0d rdy=%b, want all zero, rdy=1",
               out_valid, out_lane_v, pfx_ovf, nop_count, in_ready);
    end
    #9 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sq_mask = 6'h3F;
    apply(1, 4'b1111, g4(mk(OP_ADD), mk(OP_NOP), mk(OP_NOP), mk(OP_SUB)), 0, 1);
    vecs++;
    if (out_lane_v !== 4'b0011 || out_instr[0].opcode !== OP_ADD ||
        out_instr[1].opcode !== OP_SUB || nop_count !== 5'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic: lane_v=%b op0=%h op1=%h cnt=%0d, want 0011 ADD SUB 2",
               out_lane_v, out_instr[0].opcode, out_instr[1].opcode, nop_count);
    end
    vecs++;
    if (pack(1) !== pack(0) || rdy_seen !== rdy_exp) begin
      fails++; $display("FAIL basic_model: got %h, want %h", pack(1), pack(0));
    end
    apply(0, 4'b0000, '0, 0, 1);
    vecs++;
    if (pack(1) !== pack(0)) begin
      fails++; $display("FAIL basic_drain: got %h, want %h", pack(1), pack(0));
    end
  endtask

  task automatic test_prefix();
    instruction_t p0;
    p0 = mk(OP_PFX);
    apply(1, 4'b1111, g4(p0, mk(OP_PFX), mk(OP_ADD), mk(OP_NOP)), 0, 1);
    vecs++;
    if (out_lane_v !== 4'b0001 || out_instr[0].opcode !== OP_ADD ||
        out_pfx_cnt[0] !== 2'd2 || out_pfx[0][0] !== p0 || nop_count !== 5'd3) begin
      fails++;
      $display("FAIL prefix: lane_v=%b pcnt=%0d slot0=%h cnt=%0d, want 0001 2 %h 3",
               out_lane_v, out_pfx_cnt[0], out_pfx[0][0], nop_count, p0);
    end
    vecs++;
    if (pack(1) !== pack(0)) begin
      fails++; $display("FAIL prefix_model: got %h, want %h", pack(1), pack(0));
    end
  endtask

  task automatic test_carry();
    instruction_t pa;
    grp_t gb;
    pa = mk(OP_PFX);
    gb = g4(mk(OP_LDO), mk(OP_NOP), mk(OP_ADD), mk(OP_ADD));
    apply(1, 4'b1111, g4(mk(OP_ADD), mk(OP_SUB), mk(OP_ADD), pa), 0, 1);
    apply(1, 4'b1111, gb, 0, 1);
    vecs++;
    if (out_instr[0].opcode !== OP_LDO || out_pfx_cnt[0] !== 2'd1 || out_pfx[0][0] !== pa) begin
      fails++;
      $display("FAIL carry: op0=%h pcnt=%0d slot0=%h, want LDO 1 %h",
               out_instr[0].opcode, out_pfx_cnt[0], out_pfx[0][0], pa);
    end
    apply(1, 4'b1111, g4(mk(OP_ADD), mk(OP_SUB), mk(OP_ADD), mk(OP_PFX)), 0, 1);
    apply(0, 4'b0000, '0, 1, 1);
    apply(1, 4'b1111, gb, 0, 1);
    vecs++;
    if (out_instr[0].opcode !== OP_LDO || out_pfx_cnt[0] !== 2'd0 || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL carry_flush: op0=%h pcnt=%0d, want LDO 0", out_instr[0].opcode, out_pfx_cnt[0]);
    end
  endtask

  task automatic test_overflow();
    apply(0, 4'b0000, '0, 1, 1);
    apply(1, 4'b1111, g4(mk(OP_PFX), mk(OP_PFX), mk(OP_PFX), mk(OP_ADD)), 0, 1);
    vecs++;
    if (pfx_ovf !== 1'b1 || out_pfx_cnt[0] !== 2'd2 || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL overflow: ovf=%b pcnt=%0d, want 1 2", pfx_ovf, out_pfx_cnt[0]);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1, 4'b0011, g4(mk(OP_SUB), mk(OP_ADD), mk(OP_PFX), mk(OP_PFX)), 0, 1);
      vecs++;
      if (pfx_ovf !== 1'b1 || pack(1) !== pack(0)) begin
        fails++; $display("FAIL ovf_sticky: ovf=%b, want 1", pfx_ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    grp_t g1;
    g1 = g4(mk(OP_ADD), mk(OP_SUB), mk(OP_LDO), mk(OP_ADD));
    apply(0, 4'b0000, '0, 1, 1);
    apply(1, 4'b1111, g1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      apply(1, 4'b1111, g4(mk(OP_SUB), mk(OP_SUB), mk(OP_SUB), mk(OP_SUB)), 0, 0);
      vecs++;
      if (rdy_seen !== 1'b0 || out_valid !== 1'b1 || out_instr !== g1 || pack(1) !== pack(0)) begin
        fails++;
        $display("FAIL backpressure: rdy=%b valid=%b instr=%h, want 0 1 %h",
                 rdy_seen, out_valid, out_instr, g1);
      end
    end
    apply(1, 4'b1111, g4(mk(OP_ADD), mk(OP_NOP), mk(OP_SUB), mk(OP_NOP)), 1, 1);
    vecs++;
    if (out_valid !== 1'b0 || rdy_seen !== 1'b1 || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL flush_drop: valid=%b rdy=%b cnt=%0d, want 0 1 %0d",
               out_valid, rdy_seen, nop_count, m_cnt);
    end
    apply(0, 4'b0000, '0, 0, 1);
    vecs++;
    if (pack(1) !== pack(0)) begin
      fails++; $display("FAIL flush_after: got %h, want %h", pack(1), pack(0));
    end
  endtask

  task automatic test_mask();
    sq_mask = 6'b000001;
    apply(0, 4'b0000, '0, 1, 1);
    apply(1, 4'b1111, g4(mk(OP_PUSH), mk(OP_NOP), mk(OP_POP), mk(OP_ATOM)), 0, 1);
    vecs++;
    if (out_lane_v !== 4'b0111 || out_instr[0].opcode !== OP_PUSH ||
        out_instr[1].opcode !== OP_POP || out_instr[2].opcode !== OP_ATOM || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL mask: lane_v=%b ops=%h/%h/%h, want 0111 PUSH POP ATOM",
               out_lane_v, out_instr[0].opcode, out_instr[1].opcode, out_instr[2].opcode);
    end
  endtask

  task automatic test_saturate();
    sq_mask = 6'h3F;
    for (int k = 0; k < 10; k++)
      apply(1, 4'b1111, g4(mk(OP_NOP), mk(OP_PUSH), mk(OP_NOP), mk(OP_LEAVE)), 0, 1);
    vecs++;
    if (nop_count !== 5'h1F || out_valid !== 1'b0 || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL saturate: cnt=%0d valid=%b, want 31 0", nop_count, out_valid);
    end
  endtask

  task automatic test_random();
    logic [LANES-1:0] lv;
    grp_t g;
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) sq_mask = 6'($urandom);
      if ($urandom_range(0, 4) != 0) lv = LANES'((1 << $urandom_range(0, LANES)) - 1);
      else lv = LANES'($urandom);
      for (int i = 0; i < LANES; i++) g[i] = mk(rand_op());
      apply($urandom_range(0, 4) != 0, lv, g, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0);
      vecs++;
      if (pack(1) !== pack(0) || rdy_seen !== rdy_exp) begin
        fails++;
        $display("FAIL random[%0d]: got %h rdy %b, want %h rdy %b",
                 c, pack(1), rdy_seen, pack(0), rdy_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    sq_mask = 6'h3F;
    apply(1, 4'b1111, g4(mk(OP_ADD), mk(OP_PFX), mk(OP_PFX), mk(OP_PFX)), 0, 0);
    in_valid = 0;
    rst = 1'b0;
    #1;
    model_reset();
    vecs++;
    if ({out_valid, out_lane_v, out_instr, out_pfx, out_pfx_cnt, pfx_ovf, nop_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b lane_v=%b ovf=%b cnt=%0d, want all zero",
               out_valid, out_lane_v, pfx_ovf, nop_count);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    apply(1, 4'b1111, g4(mk(OP_LDO), mk(OP_NOP), mk(OP_SUB), mk(OP_ADD)), 0, 1);
    vecs++;
    if (out_pfx_cnt[0] !== 2'd0 || nop_count !== 5'd1 || pack(1) !== pack(0)) begin
      fails++;
      $display("FAIL after_reset: pcnt=%0d cnt=%0d, want 0 1", out_pfx_cnt[0], nop_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_carry();
    test_overflow();
    test_backpressure();
    test_mask();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
